// File: rtl/uart_log_pkg.sv
// Shared types and constants for the UART byte-log transmitter.
// The marker bytes frame log records produced by the SPI capture stage.
package uart_log_pkg;

    localparam int DEFAULT_CLK_DIV    = 417;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    localparam logic [7:0] MARKER_DD = 8'hDD;
    localparam logic [7:0] MARKER_DE = 8'hDE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/log_byte_fifo.sv
// Byte FIFO with a combinational read port (rd_data shows the head entry).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module log_byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    wr_data,
    input  logic          pop,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are log2(DEPTH) bits, so wrap is the natural binary rollover.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_log_tx.sv
// Buffers logged bytes and streams them out as 8N1 UART frames, LSB first.
// Bytes arriving while the buffer is full are dropped and counted.
module uart_log_tx
    import uart_log_pkg::*;
#(
    parameter  int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter  int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          fifo_clk,
    input  logic          reset,
    input  logic [7:0]    data,
    input  logic          data_valid,
    output logic          tx,
    output logic          uart_busy,
    output logic [LW-1:0] fifo_level,
    output logic          overflow,
    output logic [7:0]    drop_count,
    output tx_state_e     state_dbg
);

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    // Assertion is immediate; release is delayed two clocks so every flop
    // leaves reset on the same edge.
    logic [1:0] rst_sync;
    logic       rst;

    always_ff @(posedge fifo_clk or posedge reset) begin
        if (reset) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst = rst_sync[1];

    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic [7:0] fifo_rd;
    logic       drop;

    log_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (fifo_clk),
        .rst     (rst),
        .push    (data_valid),
        .wr_data (data),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign drop = data_valid && fifo_full && !pop;

    always_ff @(posedge fifo_clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    tx_state_e   state;
    tx_state_e   state_n;
    logic [15:0] baud_cnt;
    logic [15:0] baud_n;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_n;
    logic [7:0]  shift;
    logic [7:0]  shift_n;
    logic        tx_n;
    logic        baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_rd;
                    baud_n  = 16'd0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_n  = 16'd0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n  = 16'd0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n = 16'd0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_rd;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // tx is registered from the upcoming state, so it changes on the
        // same edge that enters that state.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge fifo_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'd0;
            tx        <= 1'b1;
            uart_busy <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_idx   <= bit_n;
            shift     <= shift_n;
            tx        <= tx_n;
            uart_busy <= (fifo_level != '0) || (state != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_log_tx.sv
// Directed bench for uart_log_tx with CLK_DIV=4 and a 4-deep buffer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_log_tx;
    import uart_log_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          fifo_clk   = 1'b0;
    logic          reset      = 1'b0;
    logic [7:0]    data       = 8'd0;
    logic          data_valid = 1'b0;
    logic          tx;
    logic          uart_busy;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [7:0]    drop_count;
    tx_state_e     state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    uart_log_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .fifo_clk   (fifo_clk),
        .reset      (reset),
        .data       (data),
        .data_valid (data_valid),
        .tx         (tx),
        .uart_busy  (uart_busy),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .state_dbg  (state_dbg)
    );

    always #5 fifo_clk = ~fifo_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge fifo_clk);
    endtask

    // Called at the falling edge just after the frame's first rising edge;
    // returns at the falling edge just after the edge that ends the stop bit.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < CLK_DIV; j++) begin
                check($sformatf("%s_tx_bit%0d_c%0d", tag, i, j), 32'(tx), 32'(bits[i]));
                check($sformatf("%s_busy_bit%0d_c%0d", tag, i, j), 32'(uart_busy), 32'd1);
                @(negedge fifo_clk);
            end
        end
    endtask

    logic [7:0] burst [7];
    int         low_cnt;

    initial begin
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
        burst[4] = 8'h55; burst[5] = 8'h66; burst[6] = 8'h77;

        // Reset values
        #1 reset = 1'b1;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(uart_busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        cycles(3);
        reset = 1'b0;
        cycles(3);

        // Single byte 0xA5: latency and full frame
        data = 8'hA5;
        data_valid = 1'b1;
        @(negedge fifo_clk);
        data_valid = 1'b0;
        check("a5_tx_before_start", 32'(tx), 32'd1);
        check("a5_busy_before_start", 32'(uart_busy), 32'd0);
        check("a5_level_after_push", 32'(fifo_level), 32'd1);
        @(negedge fifo_clk);
        expect_frame(8'hA5, "a5");
        check("a5_busy_after_stop", 32'(uart_busy), 32'd1);
        check("a5_state_idle", 32'(state_dbg), 32'(IDLE));
        @(negedge fifo_clk);
        check("a5_busy_fall", 32'(uart_busy), 32'd0);
        check("a5_tx_idle", 32'(tx), 32'd1);
        check("a5_level_empty", 32'(fifo_level), 32'd0);

        // Marker bytes back to back
        data = MARKER_DD;
        data_valid = 1'b1;
        @(negedge fifo_clk);
        data = MARKER_DE;
        @(negedge fifo_clk);
        data_valid = 1'b0;
        check("dd_de_level", 32'(fifo_level), 32'd1);
        expect_frame(MARKER_DD, "dd");
        expect_frame(MARKER_DE, "de");
        check("dd_de_tx_idle", 32'(tx), 32'd1);
        @(negedge fifo_clk);
        check("dd_de_busy_fall", 32'(uart_busy), 32'd0);

        // Burst of 7: one popped, four buffered, two dropped
        data = burst[0];
        data_valid = 1'b1;
        for (int i = 1; i < 7; i++) begin
            @(negedge fifo_clk);
            data = burst[i];
        end
        @(negedge fifo_clk);
        data_valid = 1'b0;
        check("burst_level", 32'(fifo_level), 32'd4);
        check("burst_overflow", 32'(overflow), 32'd1);
        check("burst_drop_count", 32'(drop_count), 32'd2);
        check("burst_busy", 32'(uart_busy), 32'd1);

        // Push on the edge where the first frame ends and pops the next byte
        cycles(34);
        check("full_before_pp_level", 32'(fifo_level), 32'd4);
        data = 8'h88;
        data_valid = 1'b1;
        @(negedge fifo_clk);
        data_valid = 1'b0;
        check("pp_level", 32'(fifo_level), 32'd4);
        check("pp_drop_count", 32'(drop_count), 32'd2);
        check("pp_overflow", 32'(overflow), 32'd1);
        expect_frame(burst[1], "b1");
        expect_frame(burst[2], "b2");
        expect_frame(burst[3], "b3");
        expect_frame(burst[4], "b4");
        expect_frame(8'h88, "b88");
        @(negedge fifo_clk);
        check("burst_drain_busy", 32'(uart_busy), 32'd0);
        check("burst_drain_level", 32'(fifo_level), 32'd0);

        // Reset during data bit 3 of a 0x00 frame with another byte queued
        data = 8'h00;
        data_valid = 1'b1;
        @(negedge fifo_clk);
        data = 8'h55;
        @(negedge fifo_clk);
        data_valid = 1'b0;
        cycles(17);
        check("mid_state_data", 32'(state_dbg), 32'(DATA));
        check("mid_tx_low", 32'(tx), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_busy", 32'(uart_busy), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_drop_count", 32'(drop_count), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge fifo_clk);
        reset = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge fifo_clk);
            if (tx !== 1'b1) low_cnt++;
        end
        check("post_rst_no_frame", 32'(low_cnt), 32'd0);
        check("post_rst_level", 32'(fifo_level), 32'd0);

        // 320 consecutive pushes: 7 accepted by edge 100, saturation at 255
        data_valid = 1'b1;
        for (int i = 0; i < 320; i++) begin
            data = 8'(i);
            @(negedge fifo_clk);
            if (i == 99) check("sat_drop_count_mid", 32'(drop_count), 32'd93);
        end
        data_valid = 1'b0;
        check("sat_drop_count", 32'(drop_count), 32'd255);
        check("sat_overflow", 32'(overflow), 32'd1);
        cycles(5);
        check("sat_drop_count_hold", 32'(drop_count), 32'd255);
        check("sat_overflow_hold", 32'(overflow), 32'd1);
        reset = 1'b1;
        #1;
        check("sat_rst_drop_count", 32'(drop_count), 32'd0);
        check("sat_rst_overflow", 32'(overflow), 32'd0);
        @(negedge fifo_clk);
        reset = 1'b0;
        cycles(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
